// File: rtl/chord_song_reader.sv
// chord_song_reader: walks a 32-entry song ROM, issuing notes to the distributor and
// counting beats on rest entries. Define SONG_LOOP_EN to loop the song instead of stopping.
module chord_song_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        beat,
  input  logic [1:0]  song,
  input  logic        voice_free,
  output logic [6:0]  rom_addr,
  input  logic [12:0] rom_data,
  output logic        load_new_note,
  output logic [5:0]  note_to_load,
  output logic [5:0]  duration_to_load,
  output logic        song_done
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, DECODE, WAIT_BEATS, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  index, index_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [1:0]  song_q;
  logic [5:0]  note_q, dur_q;
  logic        song_chg, entry_zero, advance, step, end_song;
  logic [5:0]  rom_note, rom_dur;

  assign advance    = rom_data[12];
  assign rom_note   = rom_data[11:6];
  assign rom_dur    = rom_data[5:0];
  assign entry_zero = (rom_data == 13'h0000);
  assign song_chg   = (song != song_q);
  assign rom_addr   = {song_q, index};

  // Payload is registered on issue and bypassed from the ROM during the strobe cycle itself.
  assign note_to_load     = load_new_note ? rom_note : note_q;
  assign duration_to_load = load_new_note ? rom_dur  : dur_q;

  always_comb begin
    state_nx      = state;
    index_nx      = index;
    cnt_nx        = cnt;
    load_new_note = 1'b0;
    step          = 1'b0;
    end_song      = 1'b0;
    if (song_chg) begin
      state_nx = play ? FETCH : IDLE;
      index_nx = '0;
      cnt_nx   = '0;
    end else if (play) begin
      case (state)
        IDLE:     state_nx = FETCH;
        FETCH:    state_nx = WAIT_ROM;
        WAIT_ROM: state_nx = DECODE;
        DECODE: begin
          if (entry_zero) begin
            end_song = 1'b1;
          end else if (!advance) begin
            if (voice_free) begin
              load_new_note = 1'b1;
              step          = 1'b1;
            end
          end else if (rom_dur == 6'd0) begin
            step = 1'b1;
          end else begin
            cnt_nx   = rom_dur;
            state_nx = WAIT_BEATS;
          end
        end
        WAIT_BEATS: begin
          if (beat) begin
            if (cnt <= 6'd1) begin
              cnt_nx = '0;
              step   = 1'b1;
            end else begin
              cnt_nx = cnt - 6'd1;
            end
          end
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
      if (step) begin
        state_nx = FETCH;
        if (index == 5'd31) end_song = 1'b1;
        else                index_nx = index + 5'd1;
      end
      if (end_song) begin
`ifdef SONG_LOOP_EN
        index_nx = '0;
        state_nx = FETCH;
`else
        state_nx = DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= '0;
      cnt       <= '0;
      song_q    <= song;
      note_q    <= '0;
      dur_q     <= '0;
      song_done <= 1'b0;
    end else begin
      state  <= state_nx;
      index  <= index_nx;
      cnt    <= cnt_nx;
      song_q <= song;
      if (load_new_note) begin
        note_q <= rom_note;
        dur_q  <= rom_dur;
      end
      if (song_chg)
        song_done <= 1'b0;
`ifdef SONG_LOOP_EN
      else
        song_done <= end_song;
`else
      else if (end_song)
        song_done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_chord_song_reader.sv
// Bench for chord_song_reader: directed timing scenarios plus random songs checked by a
// scoreboard of expected notes derived from walking the ROM contents in order.
module tb_chord_song_reader;
  logic        clk = 1'b0, reset = 1'b0, play = 1'b0, beat = 1'b0, voice_free = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [6:0]  rom_addr;
  logic [12:0] rom_data;
  logic        load_new_note, song_done;
  logic [5:0]  note_to_load, duration_to_load;

  logic [12:0] rom [128];
  int          checks = 0, errors = 0, cyc = 0, nstrobe = 0, last_strobe_cyc = -1, t0 = 0;
  logic [11:0] exp_q [$];
  logic [5:0]  held_note = 6'd0, held_dur = 6'd0;

  chord_song_reader dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .song(song),
    .voice_free(voice_free), .rom_addr(rom_addr), .rom_data(rom_data),
    .load_new_note(load_new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .song_done(song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected note; between strobes the payload holds.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset) begin
      held_note = 6'd0;
      held_dur  = 6'd0;
    end
    if (reset && load_new_note) begin
      nstrobe++;
      last_strobe_cyc = cyc;
      chk("strobe_voice_free", int'(voice_free), 1);
      chk("strobe_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("strobe_note", note_to_load, e[11:6]);
        chk("strobe_dur", duration_to_load, e[5:0]);
        held_note = e[11:6];
        held_dur  = e[5:0];
      end
    end else begin
      chk("held_note", note_to_load, held_note);
      chk("held_dur", duration_to_load, held_dur);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 128; i++) rom[i] = 13'h0000;
  endtask

  task automatic do_reset(logic [1:0] s, logic p, logic vf);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b0; song = s; play = p; voice_free = vf; beat = 1'b0;
    tick(2);
    chk("rst_rom_addr", rom_addr, {s, 5'd0});
    chk("rst_load", int'(load_new_note), 0);
    chk("rst_song_done", int'(song_done), 0);
    chk("rst_note", note_to_load, 0);
    chk("rst_dur", duration_to_load, 0);
    reset = 1'b1;
    t0 = cyc;
    nstrobe = 0;
  endtask

  initial begin
    logic [11:0] plan [$];
    logic [1:0]  s;
    int          len;
    logic [5:0]  n, d;
    bit          seen;
    rom_clear();

    // Two back-to-back notes, then an all-zero entry ends the song.
    rom[32] = {1'b0, 6'd20, 6'd12};
    rom[33] = {1'b0, 6'd5, 6'd7};
    do_reset(2'd1, 1'b1, 1'b1);
    exp_q.push_back({6'd20, 6'd12});
    exp_q.push_back({6'd5, 6'd7});
    chk("first_rom_addr", rom_addr, 32);
    at(t0 + 4);  chk("t1_n1", nstrobe, 1); chk("t1_c1", last_strobe_cyc, t0 + 3);
    at(t0 + 7);  chk("t1_n2", nstrobe, 2); chk("t1_c2", last_strobe_cyc, t0 + 6);
    at(t0 + 10); chk("t1_done", int'(song_done), 1);
`ifdef SONG_LOOP_EN
    chk("t1_loop_addr", rom_addr, 32);
    exp_q.push_back({6'd20, 6'd12});
    at(t0 + 11); chk("t1_done_pulse", int'(song_done), 0);
    at(t0 + 13); chk("t1_n3", nstrobe, 3); chk("t1_c3", last_strobe_cyc, t0 + 12);
`else
    chk("t1_addr_frozen", rom_addr, 34);
    at(t0 + 13); chk("t1_done_held", int'(song_done), 1); chk("t1_addr_held", rom_addr, 34);
    chk("t1_no_more", nstrobe, 2);
`endif

    // Rest of 3 beats with play dropped across 5 beats at counter 2.
    rom_clear();
    rom[32] = {1'b1, 6'd0, 6'd3};
    rom[33] = {1'b0, 6'd9, 6'd4};
    do_reset(2'd1, 1'b1, 1'b1);
    exp_q.push_back({6'd9, 6'd4});
    at(t0 + 6); pulse_beat();
    at(t0 + 8); play = 1'b0;
    for (int i = 0; i < 5; i++) begin pulse_beat(); tick(); end
    chk("t2_freeze_addr", rom_addr, 32);
    at(t0 + 18); play = 1'b1;
    at(t0 + 20); pulse_beat();
    at(t0 + 23); pulse_beat();
    at(t0 + 25); chk("t2_no_early", nstrobe, 0);
    at(t0 + 27); chk("t2_n", nstrobe, 1); chk("t2_c", last_strobe_cyc, t0 + 26);

    // Note stalled on voice_free=0 for 10 cycles.
    rom_clear();
    rom[32] = {1'b0, 6'd33, 6'd17};
    do_reset(2'd1, 1'b1, 1'b0);
    at(t0 + 13); chk("t3_stalled", nstrobe, 0);
    exp_q.push_back({6'd33, 6'd17});
    voice_free = 1'b1;
    at(t0 + 14); chk("t3_n", nstrobe, 1); chk("t3_c", last_strobe_cyc, t0 + 13);
    at(t0 + 15);

    // Reset during a stalled DECODE discards the entry; playback restarts at index 0.
    rom_clear();
    rom[32] = {1'b0, 6'd1, 6'd2};
    do_reset(2'd1, 1'b1, 1'b0);
    at(t0 + 6);
    reset = 1'b0; voice_free = 1'b1;
    tick(2);
    chk("t5_rst_load", int'(load_new_note), 0);
    chk("t5_rst_addr", rom_addr, 32);
    chk("t5_no_strobe", nstrobe, 0);
    exp_q.push_back({6'd1, 6'd2});
    reset = 1'b1; t0 = cyc; nstrobe = 0;
    at(t0 + 4); chk("t5_n", nstrobe, 1); chk("t5_c", last_strobe_cyc, t0 + 3);

    // Song switch 1->2 mid-rest, then 2->3 while song 2 has ended.
    rom_clear();
    rom[32] = {1'b1, 6'd0, 6'd40};
    rom[64] = {1'b0, 6'd11, 6'd22};
    do_reset(2'd1, 1'b1, 1'b1);
    at(t0 + 8); song = 2'd2; beat = 1'b1;
    exp_q.push_back({6'd11, 6'd22});
    at(t0 + 9); beat = 1'b0;
    chk("t4_addr", rom_addr, 64); chk("t4_done_clr", int'(song_done), 0);
    at(t0 + 12); chk("t4_n", nstrobe, 1); chk("t4_c", last_strobe_cyc, t0 + 11);
    at(t0 + 15); chk("t4_done", int'(song_done), 1);
    at(t0 + 17); song = 2'd3;
    at(t0 + 18); chk("t4_done_clr2", int'(song_done), 0); chk("t4_addr2", rom_addr, 96);
    at(t0 + 19); chk("t4_suppressed", nstrobe, 1);

    // Random songs: expected notes are the note entries in ROM order up to end of song.
    for (int r = 0; r < 4; r++) begin
      rom_clear();
      plan.delete();
      s   = 2'($urandom_range(0, 3));
      len = (r == 0) ? 32 : $urandom_range(1, 31);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 3) begin
          d = 6'($urandom_range(0, 5));
          rom[{s, 5'(i)}] = {1'b1, 6'd0, d};
        end else begin
          n = 6'($urandom_range(1, 63));
          d = 6'($urandom_range(0, 63));
          rom[{s, 5'(i)}] = {1'b0, n, d};
          plan.push_back({n, d});
        end
      end
      do_reset(s, 1'b1, 1'b1);
      foreach (plan[i]) exp_q.push_back(plan[i]);
      seen = 1'b0;
      for (int c = 0; c < 5000 && !seen; c++) begin
        play       = ($urandom_range(0, 9) != 0);
        voice_free = ($urandom_range(0, 9) < 7);
        beat       = ($urandom_range(0, 3) == 0);
        tick();
        if (song_done) seen = 1'b1;
      end
      play = 1'b0; beat = 1'b0;
      chk("rand_song_done", int'(seen), 1);
      chk("rand_strobes", nstrobe, plan.size());
      tick(2);
    end

    chk("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chord_song_reader.md
CHORD_SONG_READER -- requirements
Module: chord_song_reader

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port play, input, 1, run enable; low freezes all state.
REQ-004 SHALL have port beat, input, 1, one-cycle 48 Hz tick from the beat generator.
REQ-005 SHALL have port song, input, 2, song select (4 songs).
REQ-006 SHALL have port voice_free, input, 1, high when the note distributor has at least one idle player.
REQ-007 SHALL have port rom_addr, output, 7, {song, index[4:0]} song-ROM address.
REQ-008 SHALL have port rom_data, input, 13, {advance, note[5:0], duration[5:0]}, valid one cycle after rom_addr.
REQ-009 SHALL have port load_new_note, output, 1, one-cycle note-issue strobe to the distributor.
REQ-010 SHALL have ports note_to_load and duration_to_load, outputs, 6 each, registered payload valid while load_new_note is high.
REQ-011 SHALL have port song_done, output, 1, sticky end-of-song flag.

Function
REQ-012 SHALL implement states IDLE, FETCH, WAIT_ROM, DECODE, WAIT_BEATS, DONE.
REQ-013 SHALL move IDLE->FETCH when play=1; FETCH drives rom_addr; WAIT_ROM holds one cycle for ROM latency; DECODE samples rom_data.
REQ-014 In DECODE with advance=0 and entry nonzero: if voice_free=1, pulse load_new_note for exactly one cycle with the entry's note/duration, increment index, go to FETCH; if voice_free=0, remain in DECODE without a pulse until voice_free=1.
REQ-015 In DECODE with advance=1: duration=0 increments index and goes to FETCH; otherwise load a 6-bit beat counter with duration and go to WAIT_BEATS.
REQ-016 In WAIT_BEATS, each beat with play=1 decrements the counter; the beat that takes the counter from 1 to 0 increments index and moves to FETCH on the next cycle.
REQ-017 An all-zero entry (13'h0000) or the increment out of index 31 SHALL count as end of song (see Configuration).
REQ-018 Fetch-to-issue latency SHALL be 3 cycles (FETCH, WAIT_ROM, DECODE) with voice_free=1; back-to-back note entries issue every 3 cycles.
REQ-019 play=0 in any state SHALL freeze state, index and counter, suppress load_new_note, and ignore beat; play returning to 1 resumes in the same state.
REQ-020 A change of song versus its registered copy SHALL, on the next cycle and in any state, clear index and counter, clear song_done, suppress any pending strobe, and enter FETCH if play=1 or IDLE otherwise.
REQ-021 A beat coinciding with a song change SHALL be ignored.
REQ-022 note_to_load and duration_to_load SHALL hold their last issued values between strobes.

Reset
REQ-023 reset low SHALL asynchronously force state=IDLE, index=0, counter=0, load_new_note=0, note_to_load=0, duration_to_load=0, song_done=0, and the registered song to the current song input.
REQ-024 Reset asserted mid-WAIT_BEATS or mid-DECODE SHALL discard the pending entry; after release, playback restarts at index 0.

Configuration
REQ-025 Macro SONG_LOOP_EN SHALL select end-of-song behaviour.
REQ-026 With SONG_LOOP_EN defined, end of song SHALL set song_done for one cycle, set index to 0 and enter FETCH, giving continuous looping.
REQ-027 Without SONG_LOOP_EN, end of song SHALL enter DONE and hold song_done=1 with no further ROM activity until reset or a song change.

Verification
REQ-028 Reset, song=1, play=1, ROM[32]={0,6'd20,6'd12}, voice_free=1 -> rom_addr=7'd32, load_new_note pulses on the 3rd cycle with note=20, duration=12.
REQ-029 ROM[32]=advance, duration 3; ROM[33]=note 9 -> no strobe until 3 beats elapse, then strobe with note=9 three cycles after the third beat.
REQ-030 Note entry with voice_free=0 for 10 cycles -> no strobe for 10 cycles, then exactly one strobe in the cycle voice_free rises.
REQ-031 play dropped for 5 beats during WAIT_BEATS with counter=2 -> counter stays 2; after resume, two more beats are required.
REQ-032 ROM[34]=13'h0000 -> without SONG_LOOP_EN: song_done=1 held, rom_addr frozen; with SONG_LOOP_EN: one-cycle song_done, next rom_addr=7'd32.
REQ-033 Song switched 1->2 during WAIT_BEATS -> next cycle index=0, rom_addr=7'd64, song_done=0, no strobe from the abandoned entry.
